switch_egress_merge: RTL and testbench

Downstream stage of the 2-port address switch. Consumes the switch's port A and port B outputs (addr_x/data_x plus per-port valid) and buffers each in a small FIFO. Merges the two streams onto a single egress bus with a valid/ready handshake, using round-robin arbitration. Flags and counts drops when a port FIFO is full.

---
 rtl/switch_pkg.sv | 10 +
 rtl/switch_fifo.sv | 41 ++++
 rtl/switch_egress_merge.sv | 97 +++++++++
 tb/tb_switch_egress_merge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// switch_pkg: shared widths, port identifiers and packet type for the address switch
package switch_pkg;
  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;
endpackage

// File: rtl/switch_fifo.sv
// switch_fifo: synchronous FIFO; full is taken from the registered count, so a push while full is rejected even on a pop
module switch_fifo
  import switch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter type T = pkt_t
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic                   pop,
  input  T                       din,
  output T                       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  T mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/switch_egress_merge.sv
// switch_egress_merge: round-robin merge of switch ports A/B onto one egress bus; SWITCH_EGRESS_MERGE_STATS_EN adds forward counters
module switch_egress_merge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  vld_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  input  logic                  vld_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_src,
  output logic                  ovf_a,
  output logic                  ovf_b,
  output logic [CNT_WIDTH-1:0]  drop_cnt_a,
`ifdef SWITCH_EGRESS_MERGE_STATS_EN
  output logic [31:0]           fwd_cnt_a,
  output logic [31:0]           fwd_cnt_b,
`endif
  output logic [CNT_WIDTH-1:0]  drop_cnt_b
);
  import switch_pkg::*;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } pkt_w_t;
  pkt_w_t dout_a, dout_b;
  logic full_a, full_b, empty_a, empty_b, pop_a, pop_b;
  logic [$clog2(DEPTH):0] cnt_a, cnt_b;
  logic unused_cnt;
  logic load, any, sel_b;
  port_e last_grant;
  assign unused_cnt = ^{cnt_a, cnt_b};
  assign load  = !out_vld || out_rdy;
  assign any   = !empty_a || !empty_b;
  assign sel_b = !empty_b && (empty_a || last_grant == PORT_A);
  assign pop_a = load && any && !sel_b;
  assign pop_b = load && sel_b;
  switch_fifo #(.DEPTH(DEPTH), .T(pkt_w_t)) u_fifo_a (
    .clk(clk), .rstn(rstn), .push(vld_a), .pop(pop_a), .din({addr_a, data_a}),
    .dout(dout_a), .full(full_a), .empty(empty_a), .count(cnt_a)
  );
  switch_fifo #(.DEPTH(DEPTH), .T(pkt_w_t)) u_fifo_b (
    .clk(clk), .rstn(rstn), .push(vld_b), .pop(pop_b), .din({addr_b, data_b}),
    .dout(dout_b), .full(full_b), .empty(empty_b), .count(cnt_b)
  );
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_vld    <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
      out_src    <= 1'b0;
      last_grant <= PORT_B;
      ovf_a      <= 1'b0;
      ovf_b      <= 1'b0;
      drop_cnt_a <= '0;
      drop_cnt_b <= '0;
    end else begin
      if (load) begin
        out_vld <= any;
        if (any) begin
          out_addr   <= sel_b ? dout_b.addr : dout_a.addr;
          out_data   <= sel_b ? dout_b.data : dout_a.data;
          out_src    <= sel_b;
          last_grant <= sel_b ? PORT_B : PORT_A;
        end
      end
      if (vld_a && full_a) begin
        ovf_a <= 1'b1;
        if (~&drop_cnt_a) drop_cnt_a <= drop_cnt_a + CNT_WIDTH'(1);
      end
      if (vld_b && full_b) begin
        ovf_b <= 1'b1;
        if (~&drop_cnt_b) drop_cnt_b <= drop_cnt_b + CNT_WIDTH'(1);
      end
    end
  end
`ifdef SWITCH_EGRESS_MERGE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fwd_cnt_a <= '0;
      fwd_cnt_b <= '0;
    end else if (out_vld && out_rdy) begin
      if (out_src) fwd_cnt_b <= fwd_cnt_b + 32'd1;
      else fwd_cnt_a <= fwd_cnt_a + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_switch_egress_merge.sv
// tb_switch_egress_merge: directed self-checking bench for switch_egress_merge
module tb_switch_egress_merge;
  logic clk = 1'b0;
  logic rstn, vld_a, vld_b, out_rdy;
  logic [7:0] addr_a, addr_b, out_addr;
  logic [15:0] data_a, data_b, out_data;
  logic out_vld, out_src, ovf_a, ovf_b;
  logic [7:0] drop_cnt_a, drop_cnt_b;
`ifdef SWITCH_EGRESS_MERGE_STATS_EN
  logic [31:0] fwd_cnt_a, fwd_cnt_b;
`endif
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  switch_egress_merge dut (
    .clk(clk), .rstn(rstn),
    .vld_a(vld_a), .addr_a(addr_a), .data_a(data_a),
    .vld_b(vld_b), .addr_b(addr_b), .data_b(data_b),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_addr(out_addr), .out_data(out_data),
    .out_src(out_src), .ovf_a(ovf_a), .ovf_b(ovf_b),
`ifdef SWITCH_EGRESS_MERGE_STATS_EN
    .fwd_cnt_a(fwd_cnt_a), .fwd_cnt_b(fwd_cnt_b),
`endif
    .drop_cnt_a(drop_cnt_a), .drop_cnt_b(drop_cnt_b)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs();
    vld_a = 0; vld_b = 0; addr_a = 0; addr_b = 0; data_a = 0; data_b = 0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rstn = 0;
    step();
    step();
    rstn = 1;
  endtask
  task automatic test_reset();
    out_rdy = 1;
    do_reset();
    checks++;
    if ({out_vld, out_addr, out_data, out_src} !== 26'd0) begin
      errors++;
      $display("FAIL reset_out: got vld=%b addr=%h data=%h src=%b want all 0", out_vld, out_addr, out_data, out_src);
    end
    checks++;
    if ({ovf_a, ovf_b, drop_cnt_a, drop_cnt_b} !== 18'd0) begin
      errors++;
      $display("FAIL reset_flags: got ovf=%b%b drops=%h/%h want 0", ovf_a, ovf_b, drop_cnt_a, drop_cnt_b);
    end
  endtask
  task automatic test_single();
    do_reset();
    out_rdy = 1;
    vld_a = 1; addr_a = 8'h10; data_a = 16'h1234;
    step();
    idle_inputs();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_early: got out_vld=%b want 0", out_vld);
    end
    step();
    checks++;
    if ({out_vld, out_addr, out_data, out_src} !== {1'b1, 8'h10, 16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL single_out: got vld=%b addr=%h data=%h src=%b want 1/10/1234/0", out_vld, out_addr, out_data, out_src);
    end
    step();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL single_width: got out_vld=%b want 0", out_vld);
    end
  endtask
  task automatic test_alternate();
    logic [15:0] exp_data [8] = '{16'hA0, 16'hB0, 16'hA1, 16'hB1, 16'hA2, 16'hB2, 16'hA3, 16'hB3};
    do_reset();
    out_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      vld_a = i < 4; vld_b = i < 4;
      addr_a = 8'(i); addr_b = 8'(8'h80 + i);
      data_a = 16'(16'hA0 + i); data_b = 16'(16'hB0 + i);
      step();
      if (i >= 1 && i <= 8) begin
        checks++;
        if ({out_vld, out_data, out_src} !== {1'b1, exp_data[i-1], 1'((i - 1) % 2)}) begin
          errors++;
          $display("FAIL alternate[%0d]: got vld=%b data=%h src=%b want 1/%h/%0d", i - 1, out_vld, out_data, out_src, exp_data[i-1], (i - 1) % 2);
        end
      end
    end
    idle_inputs();
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL alternate_end: got out_vld=%b want 0", out_vld);
    end
`ifdef SWITCH_EGRESS_MERGE_STATS_EN
    checks++;
    if (fwd_cnt_a !== 32'd4 || fwd_cnt_b !== 32'd4) begin
      errors++;
      $display("FAIL fwd_cnt: got %0d/%0d want 4/4", fwd_cnt_a, fwd_cnt_b);
    end
`endif
  endtask
  task automatic test_overflow();
    do_reset();
    out_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      vld_a = 1; addr_a = 8'(8'h40 + i); data_a = 16'(16'h100 + i);
      step();
    end
    idle_inputs();
    checks++;
    if ({ovf_a, drop_cnt_a, ovf_b, drop_cnt_b} !== {1'b1, 8'd1, 1'b0, 8'd0}) begin
      errors++;
      $display("FAIL ovf_a: got ovf_a=%b drop_a=%0d ovf_b=%b drop_b=%0d want 1/1/0/0", ovf_a, drop_cnt_a, ovf_b, drop_cnt_b);
    end
    out_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if ({out_vld, out_addr, out_data} !== {1'b1, 8'(8'h40 + k), 16'(16'h100 + k)}) begin
        errors++;
        $display("FAIL drain[%0d]: got vld=%b addr=%h data=%h want 1/%h/%h", k, out_vld, out_addr, out_data, 8'(8'h40 + k), 16'(16'h100 + k));
      end
      step();
    end
    checks++;
    if (out_vld !== 1'b0) begin
      errors++;
      $display("FAIL drain_end: got out_vld=%b want 0", out_vld);
    end
  endtask
  task automatic test_stall();
    logic rdy_seq [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int hs = 0;
    do_reset();
    out_rdy = 0;
    vld_b = 1; addr_b = 8'h33; data_b = 16'h5555;
    step();
    idle_inputs();
    step();
    for (int i = 0; i < 5; i++) begin
      out_rdy = rdy_seq[i];
      if (out_vld) begin
        checks++;
        if ({out_addr, out_data, out_src} !== {8'h33, 16'h5555, 1'b1}) begin
          errors++;
          $display("FAIL stall_hold[%0d]: got addr=%h data=%h src=%b want 33/5555/1", i, out_addr, out_data, out_src);
        end
      end
      if (out_vld && out_rdy) hs++;
      step();
    end
    checks++;
    if (hs !== 1 || out_vld !== 1'b0) begin
      errors++;
      $display("FAIL stall_hs: got handshakes=%0d vld=%b want 1/0", hs, out_vld);
    end
  endtask
  task automatic test_saturate();
    do_reset();
    out_rdy = 0;
    vld_b = 1; addr_b = 8'h77; data_b = 16'hBEEF;
    for (int i = 0; i < 305; i++) step();
    idle_inputs();
    checks++;
    if ({ovf_b, drop_cnt_b} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL sat_b: got ovf_b=%b drop_b=%h want 1/ff", ovf_b, drop_cnt_b);
    end
    checks++;
    if ({ovf_a, drop_cnt_a} !== 9'd0) begin
      errors++;
      $display("FAIL sat_a_clean: got ovf_a=%b drop_a=%h want 0/00", ovf_a, drop_cnt_a);
    end
    checks++;
    if ({out_vld, out_src, out_data} !== {1'b1, 1'b1, 16'hBEEF}) begin
      errors++;
      $display("FAIL sat_out: got vld=%b src=%b data=%h want 1/1/beef", out_vld, out_src, out_data);
    end
  endtask
  task automatic test_midreset();
    do_reset();
    out_rdy = 0;
    for (int i = 0; i < 6; i++) begin
      vld_a = 1; data_a = 16'(16'hC0 + i);
      vld_b = i < 3; data_b = 16'(16'hD0 + i);
      step();
    end
    idle_inputs();
    checks++;
    if ({out_vld, ovf_a, drop_cnt_a} !== {1'b1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL pre_reset: got vld=%b ovf_a=%b drop_a=%0d want 1/1/1", out_vld, ovf_a, drop_cnt_a);
    end
    rstn = 0;
    step();
    rstn = 1;
    checks++;
    if ({out_vld, ovf_a, ovf_b, drop_cnt_a, drop_cnt_b} !== 19'd0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b ovf=%b%b drops=%h/%h want 0", out_vld, ovf_a, ovf_b, drop_cnt_a, drop_cnt_b);
    end
    out_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_vld !== 1'b0) begin
        errors++;
        $display("FAIL stale[%0d]: got out_vld=%b data=%h want 0", i, out_vld, out_data);
      end
    end
  endtask
  initial begin
    rstn = 0;
    out_rdy = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_overflow();
    test_stall();
    test_saturate();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
